// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, data base address,
// owner ids, FSM state encoding and the misalignment predicate.
package dm_arbiter_pkg;

  // Access size encodings used by the load/store unit and the DM.
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic [31:0] DATA_BASE_ADDRESS = 32'h0000_1000;

  // Owner ids for the access currently being serviced.
  localparam logic ARB_CPU = 1'b0;
  localparam logic ARB_DMA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  function automatic logic is_misaligned(logic [1:0] op, logic [1:0] addr_lo);
    return ((op == MEM_HALF) && addr_lo[0]) || ((op == MEM_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational grant selection for the DM arbiter.
// Ports:
//   cpu_req_i, dma_req_i : pending requests
//   wait_cnt_i           : consecutive CPU grants taken while DMA was pending
//   grant_valid_o        : at least one request pending
//   grant_id_o           : ARB_CPU or ARB_DMA
module dm_arb_pick
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MaxWait = 4,
  parameter int unsigned CntW    = 3
) (
  input  logic            cpu_req_i,
  input  logic            dma_req_i,
  input  logic [CntW-1:0] wait_cnt_i,
  output logic            grant_valid_o,
  output logic            grant_id_o
);

  always_comb begin
    grant_valid_o = cpu_req_i | dma_req_i;
    grant_id_o    = ARB_CPU;
    // CPU has priority until DMA has watched MaxWait CPU grants go by.
    if (dma_req_i && (!cpu_req_i || (wait_cnt_i == CntW'(MaxWait)))) begin
      grant_id_o = ARB_DMA;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single data-memory port between the CPU load/store unit and a
// DMA/debug requester. Each access runs IDLE -> ISSUE -> RESP; the winner's
// fields are held in registers that drive the DM port, and the owner gets a
// one-cycle ack with registered read data.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   cpu_*_i / cpu_*_o   : CPU request (req/wr/op/ext/addr/wdata) and response (ack/rdata/err)
//   dma_*_i / dma_*_o   : DMA request and response, same layout as CPU
//   dm_*_o, dm_dout_i   : DM port (write enable, size, extension, address, data in/out)
// Build option: define MISALIGN_TRAP_EN to answer misaligned half/word accesses
// with ack+err without touching DM; otherwise they are forwarded unchanged.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_wr_i,
  input  logic [1:0]    cpu_op_i,
  input  logic          cpu_ext_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_err_o,
  input  logic          dma_req_i,
  input  logic          dma_wr_i,
  input  logic [1:0]    dma_op_i,
  input  logic          dma_ext_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_ack_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic          dma_err_o,
  output logic          dm_wr_o,
  output logic [1:0]    dm_op_o,
  output logic          dm_ext_o,
  output logic [AW-1:0] dm_addr_o,
  output logic [DW-1:0] dm_din_o,
  input  logic [DW-1:0] dm_dout_i
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

`ifdef MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            owner_q, owner_d;
  logic            wr_q, wr_d;
  logic            ext_q, ext_d;
  logic            err_q, err_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;

  logic            grant_valid, grant_id;
  logic            sel_wr, sel_ext, trap;
  logic [1:0]      sel_op;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  dm_arb_pick #(
    .MaxWait(MAX_WAIT),
    .CntW   (CntW)
  ) u_pick (
    .cpu_req_i    (cpu_req_i),
    .dma_req_i    (dma_req_i),
    .wait_cnt_i   (wait_cnt_q),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  // Winner's request fields.
  always_comb begin
    if (grant_id == ARB_DMA) begin
      sel_wr    = dma_wr_i;
      sel_op    = dma_op_i;
      sel_ext   = dma_ext_i;
      sel_addr  = dma_addr_i;
      sel_wdata = dma_wdata_i;
    end else begin
      sel_wr    = cpu_wr_i;
      sel_op    = cpu_op_i;
      sel_ext   = cpu_ext_i;
      sel_addr  = cpu_addr_i;
      sel_wdata = cpu_wdata_i;
    end
    trap = TrapEn && is_misaligned(sel_op, sel_addr[1:0]);
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a trapped access skips the DM cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (grant_valid) state_d = trap ? ARB_RESP : ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Holding registers, starvation counter and read-data next state.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    op_d        = op_q;
    ext_d       = ext_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    if (state_q == ARB_IDLE) begin
      if (grant_valid) begin
        owner_d = grant_id;
        wr_d    = sel_wr;
        op_d    = sel_op;
        ext_d   = sel_ext;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        err_d   = trap;
        if ((grant_id == ARB_CPU) && dma_req_i) begin
          if (wait_cnt_q != CntW'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + CntW'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end else begin
        wait_cnt_d = '0;
      end
    end

    // DM read data is valid during ISSUE; stores leave rdata alone.
    if ((state_q == ARB_ISSUE) && !wr_q) begin
      if (owner_q == ARB_DMA) dma_rdata_d = dm_dout_i;
      else                    cpu_rdata_d = dm_dout_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q  <= '0;
      owner_q     <= ARB_CPU;
      wr_q        <= 1'b0;
      op_q        <= '0;
      ext_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      op_q        <= op_d;
      ext_q       <= ext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Outputs decode from registered state only; dm_wr falls with reset asynchronously.
  always_comb begin
    dm_wr_o     = (state_q == ARB_ISSUE) && wr_q;
    dm_op_o     = op_q;
    dm_ext_o    = ext_q;
    dm_addr_o   = addr_q;
    dm_din_o    = wdata_q;
    cpu_ack_o   = (state_q == ARB_RESP) && (owner_q == ARB_CPU);
    dma_ack_o   = (state_q == ARB_RESP) && (owner_q == ARB_DMA);
    cpu_err_o   = cpu_ack_o && err_q;
    dma_err_o   = dma_ack_o && err_q;
    cpu_rdata_o = cpu_rdata_q;
    dma_rdata_o = dma_rdata_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a byte-addressed DM model: directed
// scenarios followed by randomized two-requester traffic against a
// transaction-level reference.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_wr, cpu_ext, cpu_ack, cpu_err;
  logic [1:0]    cpu_op;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_wr, dma_ext, dma_ack, dma_err;
  logic [1:0]    dma_op;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dm_wr, dm_ext;
  logic [1:0]    dm_op;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din, dm_dout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] dmem    [256];
  logic [7:0] ref_mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dm_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_op_i(cpu_op), .cpu_ext_i(cpu_ext),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
    .dma_req_i(dma_req), .dma_wr_i(dma_wr), .dma_op_i(dma_op), .dma_ext_i(dma_ext),
    .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata), .dma_err_o(dma_err),
    .dm_wr_o(dm_wr), .dm_op_o(dm_op), .dm_ext_o(dm_ext), .dm_addr_o(dm_addr),
    .dm_din_o(dm_din), .dm_dout_i(dm_dout)
  );

  function automatic logic [31:0] shape_load(logic [31:0] raw, logic [1:0] op, logic ext);
    case (op)
      MEM_BYTE: return ext ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      MEM_HALF: return ext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default:  return raw;
    endcase
  endfunction

  // DM: combinational read, write on posedge, 256-byte little-endian window.
  always_comb begin
    logic [7:0] a;
    a = dm_addr[7:0];
    dm_dout = shape_load({dmem[a + 8'd3], dmem[a + 8'd2], dmem[a + 8'd1], dmem[a]}, dm_op, dm_ext);
  end

  always @(posedge clk) begin
    if (dm_wr) begin
      dmem[dm_addr[7:0]] <= dm_din[7:0];
      if (dm_op != MEM_BYTE) dmem[dm_addr[7:0] + 8'd1] <= dm_din[15:8];
      if (dm_op == MEM_WORD) begin
        dmem[dm_addr[7:0] + 8'd2] <= dm_din[23:16];
        dmem[dm_addr[7:0] + 8'd3] <= dm_din[31:24];
      end
    end
  end

  function automatic logic [31:0] ref_load(logic [31:0] addr, logic [1:0] op, logic ext);
    logic [7:0] a;
    a = addr[7:0];
    return shape_load({ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]},
                      op, ext);
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] op, input logic [31:0] d);
    logic [7:0] a;
    a = addr[7:0];
    ref_mem[a] = d[7:0];
    if (op != MEM_BYTE) ref_mem[a + 8'd1] = d[15:8];
    if (op == MEM_WORD) begin
      ref_mem[a + 8'd2] = d[23:16];
      ref_mem[a + 8'd3] = d[31:24];
    end
  endtask

  function automatic logic [31:0] dm_word(logic [31:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    return {dmem[a + 8'd3], dmem[a + 8'd2], dmem[a + 8'd1], dmem[a]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One directed access; called at posedge+1. Latency counts negedge samples up to
  // and including the ack sample; wr_mask bit i marks dm_wr high at sample i.
  task automatic do_access(input logic who, input logic wr, input logic [1:0] op,
                           input logic ext, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int wr_mask, output logic [31:0] rdata,
                           output logic err);
    if (who == ARB_CPU) begin
      cpu_wr = wr; cpu_op = op; cpu_ext = ext; cpu_addr = addr; cpu_wdata = wdata;
      cpu_req = 1'b1;
    end else begin
      dma_wr = wr; dma_op = op; dma_ext = ext; dma_addr = addr; dma_wdata = wdata;
      dma_req = 1'b1;
    end
    lat = 0; wr_mask = 0; rdata = '0; err = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (dm_wr) wr_mask |= (1 << i);
      if (who == ARB_CPU ? cpu_ack : dma_ack) begin
        lat   = i;
        rdata = (who == ARB_CPU) ? cpu_rdata : dma_rdata;
        err   = (who == ARB_CPU) ? cpu_err : dma_err;
        check_eq("other_ack_quiet", (who == ARB_CPU) ? dma_ack : cpu_ack, 1'b0);
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic rand_fields(output logic wr, output logic [1:0] op, output logic ext,
                             output logic [31:0] addr, output logic [31:0] wdata);
    int unsigned off;
    wr   = 1'($urandom_range(0, 1));
    op   = 2'($urandom_range(0, 2));
    ext  = 1'($urandom_range(0, 1));
    off  = $urandom_range(0, 63);
    if (op == MEM_HALF) off = off & ~32'd1;
    if (op == MEM_WORD) off = off & ~32'd3;
    addr  = DATA_BASE_ADDRESS + off;
    wdata = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, wmask, acks;
    logic [31:0] rd;
    logic        er;
    logic [31:0] b;
    // Reference-model state for the random phase
    int          m_busy, m_wins;
    logic        m_owner, m_wr, win, exp_c, exp_d, c_done, d_done;
    logic [31:0] m_rdata;

    b = DATA_BASE_ADDRESS;
    rst = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_op = 0; cpu_ext = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_wr = 0; dma_op = 0; dma_ext = 0; dma_addr = 0; dma_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cpu_ack", cpu_ack, 0);
    check_eq("rst_dma_ack", dma_ack, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    check_eq("rst_cpu_err", cpu_err, 0);
    check_eq("rst_dm_wr", dm_wr, 0);
    check_eq("rst_dm_fields", {dm_op, dm_ext, dm_addr, dm_din}, 0);
    rst = 1'b0;

    // Store word then load it back.
    do_access(ARB_CPU, 1'b1, MEM_WORD, 1'b0, b + 8, 32'hDEADBEEF, lat, wmask, rd, er);
    ref_store(b + 8, MEM_WORD, 32'hDEADBEEF);
    check_eq("sw_latency", lat, 3);
    check_eq("sw_dm_wr_issue_only", wmask, 32'h4);
    check_eq("sw_rdata_unchanged", rd, 0);
    check_eq("sw_err", er, 0);
    do_access(ARB_CPU, 1'b0, MEM_WORD, 1'b0, b + 8, 32'h0, lat, wmask, rd, er);
    check_eq("lw_latency", lat, 3);
    check_eq("lw_rdata", rd, 32'hDEADBEEF);
    check_eq("lw_no_dm_wr", wmask, 0);
    @(negedge clk);
    check_eq("ack_one_cycle", cpu_ack, 0);
    check_eq("rdata_held", cpu_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Byte load with sign and zero extension.
    do_access(ARB_CPU, 1'b1, MEM_BYTE, 1'b0, b + 9, 32'h0000_0080, lat, wmask, rd, er);
    ref_store(b + 9, MEM_BYTE, 32'h80);
    do_access(ARB_CPU, 1'b0, MEM_BYTE, 1'b1, b + 9, 32'h0, lat, wmask, rd, er);
    check_eq("lb_sext", rd, 32'hFFFFFF80);
    do_access(ARB_CPU, 1'b0, MEM_BYTE, 1'b0, b + 9, 32'h0, lat, wmask, rd, er);
    check_eq("lbu_zext", rd, 32'h00000080);

    // DMA as the only requester.
    do_access(ARB_DMA, 1'b1, MEM_WORD, 1'b0, b + 32'h20, 32'h0BAD_CAFE, lat, wmask, rd, er);
    ref_store(b + 32'h20, MEM_WORD, 32'h0BAD_CAFE);
    check_eq("dma_sw_latency", lat, 3);
    do_access(ARB_DMA, 1'b0, MEM_WORD, 1'b0, b + 32'h20, 32'h0, lat, wmask, rd, er);
    check_eq("dma_lw_latency", lat, 3);
    check_eq("dma_lw_rdata", rd, 32'h0BAD_CAFE);

    // Both held high: four CPU grants then one DMA grant, repeating.
    cpu_wr = 0; cpu_op = MEM_WORD; cpu_ext = 0; cpu_addr = b + 8;
    dma_wr = 0; dma_op = MEM_WORD; dma_ext = 0; dma_addr = b + 32'h20;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 80 && acks < 10; i++) begin
      @(negedge clk);
      check_eq("dual_ack", cpu_ack & dma_ack, 0);
      if (cpu_ack | dma_ack) begin
        check_eq("grant_order_dma", dma_ack, (acks % 5) == 4);
        if (cpu_ack) check_eq("cont_cpu_rdata", cpu_rdata, ref_load(b + 8, MEM_WORD, 1'b0));
        if (dma_ack) check_eq("cont_dma_rdata", dma_rdata, ref_load(b + 32'h20, MEM_WORD, 1'b0));
        acks++;
      end
    end
    check_eq("cont_ack_count", acks, 10);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;

    // Reset during the ISSUE cycle of a store.
    do_access(ARB_CPU, 1'b1, MEM_WORD, 1'b0, b + 32'h10, 32'hA5A5A5A5, lat, wmask, rd, er);
    ref_store(b + 32'h10, MEM_WORD, 32'hA5A5A5A5);
    cpu_wr = 1; cpu_op = MEM_WORD; cpu_ext = 0; cpu_addr = b + 32'h10; cpu_wdata = 32'h12345678;
    cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_in_issue", dm_wr, 1);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    check_eq("abort_dm_wr_async", dm_wr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_ack", cpu_ack, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_mem_unchanged", dm_word(b + 32'h10), 32'hA5A5A5A5);
    check_eq("abort_rdata_cleared", cpu_rdata, 0);
    do_access(ARB_CPU, 1'b0, MEM_WORD, 1'b0, b + 32'h10, 32'h0, lat, wmask, rd, er);
    check_eq("post_abort_latency", lat, 3);
    check_eq("post_abort_rdata", rd, 32'hA5A5A5A5);

    // Misaligned word store.
    do_access(ARB_CPU, 1'b1, MEM_WORD, 1'b0, b + 32'h22, 32'hCAFEF00D, lat, wmask, rd, er);
`ifdef MISALIGN_TRAP_EN
    check_eq("mis_latency", lat, 2);
    check_eq("mis_err", er, 1);
    check_eq("mis_no_dm_wr", wmask, 0);
`else
    ref_store(b + 32'h22, MEM_WORD, 32'hCAFEF00D);
    check_eq("mis_latency", lat, 3);
    check_eq("mis_err", er, 0);
    check_eq("mis_dm_wr", wmask, 32'h4);
`endif
    check_eq("mis_rdata_unchanged", rd, 32'hA5A5A5A5);
    check_eq("mis_mem", dm_word(b + 32'h20), ref_load(b + 32'h20, MEM_WORD, 1'b0));

    // Randomized traffic against a transaction-level reference.
    for (int i = 0; i < 256; i++) ref_mem[i] = dmem[i];
    m_busy = 0; m_wins = 0; m_owner = ARB_CPU; m_wr = 1'b0; m_rdata = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      exp_c = (m_busy == 1) && (m_owner == ARB_CPU);
      exp_d = (m_busy == 1) && (m_owner == ARB_DMA);
      check_eq("rnd_cpu_ack", cpu_ack, exp_c);
      check_eq("rnd_dma_ack", dma_ack, exp_d);
      if (exp_c && !m_wr) check_eq("rnd_cpu_rdata", cpu_rdata, m_rdata);
      if (exp_d && !m_wr) check_eq("rnd_dma_rdata", dma_rdata, m_rdata);
      if (exp_c) check_eq("rnd_cpu_err", cpu_err, 0);
      if (exp_d) check_eq("rnd_dma_err", dma_err, 0);
      c_done = exp_c;
      d_done = exp_d;
      // Advance the reference over the coming edge.
      if (m_busy == 0) begin
        if (cpu_req || dma_req) begin
          win    = (dma_req && (!cpu_req || m_wins == MAX_WAIT)) ? ARB_DMA : ARB_CPU;
          m_wins = (win == ARB_CPU && dma_req) ? ((m_wins < MAX_WAIT) ? m_wins + 1 : m_wins)
                                               : 0;
          m_owner = win;
          if (win == ARB_CPU) begin
            m_wr = cpu_wr;
            if (cpu_wr) ref_store(cpu_addr, cpu_op, cpu_wdata);
            else        m_rdata = ref_load(cpu_addr, cpu_op, cpu_ext);
          end else begin
            m_wr = dma_wr;
            if (dma_wr) ref_store(dma_addr, dma_op, dma_wdata);
            else        m_rdata = ref_load(dma_addr, dma_op, dma_ext);
          end
          m_busy = 2;
        end else begin
          m_wins = 0;
        end
      end else begin
        m_busy--;
      end
      @(posedge clk);
      #1;
      if (c_done) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        rand_fields(cpu_wr, cpu_op, cpu_ext, cpu_addr, cpu_wdata);
      end else if (!cpu_req && ($urandom_range(0, 2) == 0)) begin
        cpu_req = 1'b1;
        rand_fields(cpu_wr, cpu_op, cpu_ext, cpu_addr, cpu_wdata);
      end
      if (d_done) begin
        dma_req = ($urandom_range(0, 3) != 0);
        rand_fields(dma_wr, dma_op, dma_ext, dma_addr, dma_wdata);
      end else if (!dma_req && ($urandom_range(0, 2) == 0)) begin
        dma_req = 1'b1;
        rand_fields(dma_wr, dma_op, dma_ext, dma_addr, dma_wdata);
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
